// File: rtl/input_turn_queue.sv
// Direction button front end: synchronise and debounce four active-low buttons,
// turn presses into single events, and queue accepted turns for the game tick.
module input_turn_queue #(
  parameter int         DEB_CYCLES = 250000,
  parameter int         QDEPTH     = 4,
  parameter logic [1:0] INIT_DIR   = 2'd3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   btn_n,
  input  logic                         tick,
  output logic [1:0]                   dir,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count,
  output logic [3:0]                   btn_state,
  output logic                         reject
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] Q_FULL  = CW'(QDEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(QDEPTH - 1);

  // Per-button synchroniser and debouncer; the stable level is kept active-low
  // so it can be compared directly against the synchronised input.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          stable_n_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg    <= 1'b1;
          sync2_reg    <= 1'b1;
          stable_n_reg <= 1'b1;
          cnt_reg      <= '0;
        end else begin
          sync1_reg <= btn_n[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == stable_n_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_MAX) begin
            stable_n_reg <= ~stable_n_reg;
            cnt_reg      <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign btn_state[gi] = ~stable_n_reg;
    end
  endgenerate

  logic [3:0]    pressed_d_reg;
  logic [3:0]    evt;
  logic [1:0]    dir_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic          reject_reg;
  logic [1:0]    mem [QDEPTH];

  logic          win_valid;
  logic [1:0]    win_dir;
  logic          lose;
  logic [PW-1:0] tail_ptr;
  logic [1:0]    ref_dir;
  logic          full;
  logic          pop;
  logic          push;
  logic          reject_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign evt      = btn_state & ~pressed_d_reg;
  assign tail_ptr = (wr_ptr_reg == '0) ? PTR_MAX : wr_ptr_reg - 1'b1;
  assign ref_dir  = (count_reg != '0) ? mem[tail_ptr] : dir_reg;
  assign full     = (count_reg == Q_FULL);
  assign pop      = tick && (count_reg != '0);

  // Lowest index wins (UP > LEFT > DOWN > RIGHT); every other event is a loser.
  always_comb begin
    win_valid = 1'b0;
    win_dir   = 2'd0;
    lose      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (evt[i]) begin
        if (!win_valid) begin
          win_valid = 1'b1;
          win_dir   = 2'(i);
        end else begin
          lose = 1'b1;
        end
      end
    end
  end

  // Opposite directions differ only in bit 1 (UP/DOWN = 0/2, LEFT/RIGHT = 1/3).
  always_comb begin
    push        = 1'b0;
    reject_next = lose;
    if (win_valid && (win_dir != ref_dir)) begin
      if ((win_dir ^ ref_dir) == 2'd2) begin
        reject_next = 1'b1;
      end else if (full && !pop) begin
        reject_next = 1'b1;
      end else begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_d_reg <= '0;
      dir_reg       <= INIT_DIR;
      count_reg     <= '0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      reject_reg    <= 1'b0;
    end else begin
      pressed_d_reg <= btn_state;
      reject_reg    <= reject_next;
      if (pop) begin
        dir_reg    <= mem[rd_ptr_reg];
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= win_dir;
    end
  end

  assign dir     = dir_reg;
  assign q_count = count_reg;
  assign reject  = reject_reg;

endmodule

// File: tb/tb_input_turn_queue.sv
// Bench for input_turn_queue: directed scenarios then random button/tick traffic,
// checked every cycle against a queue-based behavioural model.
module tb_input_turn_queue;

  localparam int DEB = 4;
  localparam int QD  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic       tick = 1'b0;
  logic [1:0] dir;
  logic [1:0] q_count;
  logic [3:0] btn_state;
  logic       reject;

  int n_cmp = 0;
  int n_err = 0;

  input_turn_queue #(
    .DEB_CYCLES(DEB),
    .QDEPTH    (QD),
    .INIT_DIR  (2'd3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_n    (btn_n),
    .tick     (tick),
    .dir      (dir),
    .q_count  (q_count),
    .btn_state(btn_state),
    .reject   (reject)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [1:0] m_dir;
  logic [1:0] m_q[$];
  logic [3:0] m_pressed;
  logic       m_hist[4][$];
  logic [3:0] m_dl[$];
  logic [3:0] m_evt;
  logic       m_rej;

  task automatic model_reset();
    m_dir = 2'd3;
    m_q.delete();
    m_pressed = 4'h0;
    for (int i = 0; i < 4; i++) m_hist[i].delete();
    m_dl.delete();
    m_dl.push_back(4'hF);
    m_dl.push_back(4'hF);
    m_evt = 4'h0;
    m_rej = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] b, input logic t);
    logic       found;
    logic       acc;
    logic [1:0] e;
    logic [1:0] refd;
    logic [3:0] s;
    logic       all_diff;
    if (r) begin
      model_reset();
      return;
    end
    // Turn decision for events raised on the previous edge
    m_rej = 1'b0;
    found = 1'b0;
    acc   = 1'b0;
    e     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m_evt[i]) begin
        if (found) m_rej = 1'b1;
        else begin
          found = 1'b1;
          e = 2'(i);
        end
      end
    end
    if (found) begin
      refd = (m_q.size() > 0) ? m_q[$] : m_dir;
      if (e != refd) begin
        if ((e ^ refd) == 2'd2) m_rej = 1'b1;
        else if (m_q.size() == QD && !(t && m_q.size() > 0)) m_rej = 1'b1;
        else acc = 1'b1;
      end
    end
    if (t && m_q.size() > 0) m_dir = m_q.pop_front();
    if (acc) m_q.push_back(e);
    // Debounce: flip once the last DEB synchronised samples all disagree
    s = m_dl.pop_front();
    m_dl.push_back(b);
    m_evt = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_hist[i].push_back(s[i]);
      if (m_hist[i].size() > DEB) void'(m_hist[i].pop_front());
      all_diff = (m_hist[i].size() == DEB);
      foreach (m_hist[i][j]) if (m_hist[i][j] != m_pressed[i]) all_diff = 1'b0;
      if (all_diff) begin
        m_pressed[i] = ~m_pressed[i];
        if (m_pressed[i]) m_evt[i] = 1'b1;
        m_hist[i].delete();
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] b, input logic t);
    @(negedge clk);
    rst   = r;
    btn_n = b;
    tick  = t;
    @(posedge clk);
    model_edge(r, b, t);
    #1;
    check("dir", 8'(dir), 8'(m_dir));
    check("q_count", 8'(q_count), 8'(m_q.size()));
    check("btn_state", 8'(btn_state), 8'(m_pressed));
    check("reject", 8'(reject), 8'(m_rej));
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, b, 1'b0);
  endtask

  task automatic press(input int idx);
    logic [3:0] b;
    b = 4'hF;
    b[idx] = 1'b0;
    hold(b, 8);
    hold(4'hF, 7);
  endtask

  // Press with tick raised exactly in the cycle the event is evaluated
  task automatic press_tick(input int idx);
    logic [3:0] b;
    b = 4'hF;
    b[idx] = 1'b0;
    for (int k = 0; k < 10; k++) cyc(1'b0, b, |m_evt);
    hold(4'hF, 7);
  endtask

  initial begin
    logic [3:0] b;
    int         r;
    int         len;
    model_reset();
    cyc(1'b1, 4'hF, 1'b0);
    cyc(1'b1, 4'hF, 1'b0);
    // Debounce: short glitch, then a real hold
    hold(4'b1110, 3);
    hold(4'hF, 6);
    hold(4'b1110, 10);
    hold(4'hF, 7);
    // Queue order
    press(1);
    cyc(1'b0, 4'hF, 1'b1);
    cyc(1'b0, 4'hF, 1'b1);
    // Tail-based 180 degree block
    cyc(1'b1, 4'hF, 1'b0);
    press(3);
    press(0);
    press(2);
    press(1);
    // Full queue, then full queue with coincident tick
    press(2);
    press_tick(2);
    // Simultaneous UP and LEFT
    cyc(1'b1, 4'hF, 1'b0);
    hold(4'b1100, 10);
    hold(4'hF, 7);
    // Reset mid-operation with UP held through reset
    cyc(1'b1, 4'hF, 1'b0);
    press(0);
    press(1);
    hold(4'b1011, 2);
    cyc(1'b1, 4'b1110, 1'b0);
    hold(4'b1110, 10);
    hold(4'hF, 7);
    // Random traffic
    for (int it = 0; it < 400; it++) begin
      b = 4'hF;
      r = $urandom_range(0, 9);
      if (r < 5) b[$urandom_range(0, 3)] = 1'b0;
      else if (r == 5) b = 4'($urandom);
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++)
        cyc(($urandom_range(0, 299) == 0), b, ($urandom_range(0, 3) == 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
